nap_alarm_trigger: RTL and testbench

//  Consumer side of the shortcut nap setting path: latches the BCD target wake time
//  on the completeSetting rising edge, compares it against the running clock, and

---
 rtl/nap_alarm_trigger.sv | 152 +++++++++++++++
 tb/tb_nap_alarm_trigger.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nap_alarm_trigger.sv
// Nap alarm consumer: latches a BCD wake target, counts down against the running clock,
// then rings with a blink pattern until dismissed, snoozed or timed out.
module nap_alarm_trigger #(
  parameter int CLK_PER_SEC = 1000,
  parameter int RING_SEC    = 30,
  parameter int BLINK_CYC   = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        completeSetting,
  input  logic        sharp,
  input  logic [3:0]  hour_ten_tgt,
  input  logic [3:0]  hour_one_tgt,
  input  logic [3:0]  min_ten_tgt,
  input  logic [3:0]  min_one_tgt,
  input  logic [3:0]  sec_ten_tgt,
  input  logic [3:0]  sec_one_tgt,
  input  logic [3:0]  hour_ten_now,
  input  logic [3:0]  hour_one_now,
  input  logic [3:0]  min_ten_now,
  input  logic [3:0]  min_one_now,
  input  logic [3:0]  sec_ten_now,
  input  logic [3:0]  sec_one_now,
  output logic        armed,
  output logic        alarm_on,
  output logic        alarm_blink,
  output logic [16:0] remain_sec,
  output logic        set_err
);

  localparam int RING_LEN = RING_SEC * CLK_PER_SEC;
  localparam int RW       = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;
  localparam int BW       = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;

  state_t          state_reg, state_next;
  logic            cs_d_reg, sh_d_reg;
  logic [3:0]      ht_reg, ho_reg, mt_reg, mo_reg, st_reg, so_reg;
  logic [16:0]     remain_reg;
  logic            set_err_reg;
  logic [RW-1:0]   ring_cnt_reg;
  logic [BW-1:0]   blink_cnt_reg;
  logic            blink_reg;

  function automatic logic [16:0] to_sec(input logic [3:0] ht, input logic [3:0] ho,
                                         input logic [3:0] mt, input logic [3:0] mo,
                                         input logic [3:0] st, input logic [3:0] so);
    logic [16:0] h, m, s;
    h = 17'(ht) * 17'd10 + 17'(ho);
    m = 17'(mt) * 17'd10 + 17'(mo);
    s = 17'(st) * 17'd10 + 17'(so);
    return h * 17'd3600 + m * 17'd60 + s;
  endfunction

  // Distance forward in time from now to target, wrapping through midnight.
  function automatic logic [16:0] fwd_diff(input logic [16:0] t_tgt, input logic [16:0] t_now);
    logic [17:0] d;
    if (t_tgt >= t_now) d = {1'b0, t_tgt} - {1'b0, t_now};
    else                d = {1'b0, t_tgt} + 18'd86400 - {1'b0, t_now};
    return d[16:0];
  endfunction

  logic        cs_rise, sh_rise, tgt_valid, load;
  logic [16:0] t_now, t_tgt_reg, t_tgt_eff, diff_reg, diff_eff;

  assign cs_rise = completeSetting & ~cs_d_reg;
  assign sh_rise = sharp & ~sh_d_reg;

  assign tgt_valid = (hour_one_tgt <= 4'd9) && (min_one_tgt <= 4'd9) && (sec_one_tgt <= 4'd9)
                  && (min_ten_tgt <= 4'd5) && (sec_ten_tgt <= 4'd5)
                  && ((hour_ten_tgt < 4'd2) || (hour_ten_tgt == 4'd2 && hour_one_tgt <= 4'd3));

  assign load = en & cs_rise & tgt_valid;

  assign t_now     = to_sec(hour_ten_now, hour_one_now, min_ten_now, min_one_now, sec_ten_now, sec_one_now);
  assign t_tgt_reg = to_sec(ht_reg, ho_reg, mt_reg, mo_reg, st_reg, so_reg);
  // Display value must reflect a target being loaded on this very edge.
  assign t_tgt_eff = load ? to_sec(hour_ten_tgt, hour_one_tgt, min_ten_tgt, min_one_tgt,
                                   sec_ten_tgt, sec_one_tgt) : t_tgt_reg;
  assign diff_reg  = fwd_diff(t_tgt_reg, t_now);
  assign diff_eff  = fwd_diff(t_tgt_eff, t_now);

  always_comb begin
    state_next = state_reg;
    if (en) begin
      case (state_reg)
        IDLE:    if (load) state_next = ARMED;
        ARMED: begin
          if (load)                 state_next = ARMED;
          else if (diff_reg == '0)  state_next = RINGING;
          else if (sh_rise)         state_next = IDLE;
        end
        RINGING: begin
          if (load)                                     state_next = ARMED;
          else if (sh_rise)                             state_next = IDLE;
          else if (ring_cnt_reg == RW'(RING_LEN - 1))   state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cs_d_reg      <= completeSetting;
      sh_d_reg      <= sharp;
      {ht_reg, ho_reg, mt_reg, mo_reg, st_reg, so_reg} <= '0;
      remain_reg    <= '0;
      set_err_reg   <= 1'b0;
      ring_cnt_reg  <= '0;
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else if (en) begin
      cs_d_reg    <= completeSetting;
      sh_d_reg    <= sharp;
      state_reg   <= state_next;
      set_err_reg <= cs_rise & ~tgt_valid;
      remain_reg  <= (state_next == ARMED) ? diff_eff : 17'd0;
      if (load) begin
        {ht_reg, ho_reg, mt_reg, mo_reg, st_reg, so_reg} <=
          {hour_ten_tgt, hour_one_tgt, min_ten_tgt, min_one_tgt, sec_ten_tgt, sec_one_tgt};
      end
      if (state_next == RINGING && state_reg != RINGING) begin
        ring_cnt_reg  <= '0;
        blink_cnt_reg <= '0;
        blink_reg     <= 1'b1;
      end else if (state_next == RINGING) begin
        ring_cnt_reg <= ring_cnt_reg + 1'b1;
        if (blink_cnt_reg == BW'(BLINK_CYC - 1)) begin
          blink_cnt_reg <= '0;
          blink_reg     <= ~blink_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end else begin
        ring_cnt_reg  <= '0;
        blink_cnt_reg <= '0;
        blink_reg     <= 1'b0;
      end
    end
  end

  assign armed       = (state_reg == ARMED);
  assign alarm_on    = (state_reg == RINGING);
  assign alarm_blink = blink_reg;
  assign remain_sec  = remain_reg;
  assign set_err     = set_err_reg;

endmodule

// File: tb/tb_nap_alarm_trigger.sv
// Directed bench for nap_alarm_trigger with short timing parameters
// (10 cycles/s, 3 s ring, 4-cycle blink half-period).
module tb_nap_alarm_trigger;

  logic        clk = 1'b0;
  logic        rst, en, completeSetting, sharp;
  logic [3:0]  hour_ten_tgt, hour_one_tgt, min_ten_tgt, min_one_tgt, sec_ten_tgt, sec_one_tgt;
  logic [3:0]  hour_ten_now, hour_one_now, min_ten_now, min_one_now, sec_ten_now, sec_one_now;
  logic        armed, alarm_on, alarm_blink, set_err;
  logic [16:0] remain_sec;

  int errors = 0;
  int checks = 0;

  nap_alarm_trigger #(.CLK_PER_SEC(10), .RING_SEC(3), .BLINK_CYC(4)) dut (
    .clk(clk), .rst(rst), .en(en), .completeSetting(completeSetting), .sharp(sharp),
    .hour_ten_tgt(hour_ten_tgt), .hour_one_tgt(hour_one_tgt),
    .min_ten_tgt(min_ten_tgt), .min_one_tgt(min_one_tgt),
    .sec_ten_tgt(sec_ten_tgt), .sec_one_tgt(sec_one_tgt),
    .hour_ten_now(hour_ten_now), .hour_one_now(hour_one_now),
    .min_ten_now(min_ten_now), .min_one_now(min_one_now),
    .sec_ten_now(sec_ten_now), .sec_one_now(sec_one_now),
    .armed(armed), .alarm_on(alarm_on), .alarm_blink(alarm_blink),
    .remain_sec(remain_sec), .set_err(set_err)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs and samples happen 1 time unit after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_now(input int h, input int m, input int s);
    hour_ten_now = 4'(h / 10); hour_one_now = 4'(h % 10);
    min_ten_now  = 4'(m / 10); min_one_now  = 4'(m % 10);
    sec_ten_now  = 4'(s / 10); sec_one_now  = 4'(s % 10);
  endtask

  task automatic set_tgt(input int h, input int m, input int s);
    hour_ten_tgt = 4'(h / 10); hour_one_tgt = 4'(h % 10);
    min_ten_tgt  = 4'(m / 10); min_one_tgt  = 4'(m % 10);
    sec_ten_tgt  = 4'(s / 10); sec_one_tgt  = 4'(s % 10);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; sharp = 1'b0;
    completeSetting = 1'b1;
    set_now(12, 0, 0); set_tgt(12, 0, 30);
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++;
    if ({armed, alarm_on, alarm_blink, set_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {armed, alarm_on, alarm_blink, set_err});
    end
    checks++;
    if (remain_sec !== 17'd0) begin
      errors++; $display("FAIL reset_remain: got %0d expected 0", remain_sec);
    end
    tick(2);
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL reset_held_cs: armed got %b expected 0", armed);
    end
    completeSetting = 1'b0;
    tick(1);
    $display("test_reset done");
  endtask

  task automatic test_arm;
    set_now(12, 0, 0); set_tgt(12, 0, 30);
    completeSetting = 1'b1;
    tick(1);
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL arm_armed: got %b expected 1", armed);
    end
    checks++;
    if (remain_sec !== 17'd30) begin
      errors++; $display("FAIL arm_remain: got %0d expected 30", remain_sec);
    end
    completeSetting = 1'b0;
    set_now(12, 0, 10);
    tick(1);
    checks++;
    if (remain_sec !== 17'd20) begin
      errors++; $display("FAIL arm_countdown: got %0d expected 20", remain_sec);
    end
    $display("test_arm done");
  endtask

  task automatic test_ring_blink;
    set_now(12, 0, 30);
    tick(1);
    checks++;
    if ({armed, alarm_on, alarm_blink} !== 3'b011) begin
      errors++; $display("FAIL ring_start: armed/on/blink got %b expected 011", {armed, alarm_on, alarm_blink});
    end
    checks++;
    if (remain_sec !== 17'd0) begin
      errors++; $display("FAIL ring_remain: got %0d expected 0", remain_sec);
    end
    tick(3);
    checks++;
    if (alarm_blink !== 1'b1) begin
      errors++; $display("FAIL blink_hi_end: got %b expected 1", alarm_blink);
    end
    tick(1);
    checks++;
    if (alarm_blink !== 1'b0) begin
      errors++; $display("FAIL blink_toggle_lo: got %b expected 0", alarm_blink);
    end
    tick(4);
    checks++;
    if (alarm_blink !== 1'b1) begin
      errors++; $display("FAIL blink_toggle_hi: got %b expected 1", alarm_blink);
    end
    $display("test_ring_blink done");
  endtask

  task automatic test_dismiss;
    sharp = 1'b1;
    tick(1);
    checks++;
    if ({armed, alarm_on, alarm_blink} !== 3'b000) begin
      errors++; $display("FAIL dismiss: armed/on/blink got %b expected 000", {armed, alarm_on, alarm_blink});
    end
    tick(3);
    checks++;
    if ({armed, alarm_on} !== 2'b00) begin
      errors++; $display("FAIL dismiss_hold: armed/on got %b expected 00", {armed, alarm_on});
    end
    sharp = 1'b0;
    tick(1);
    $display("test_dismiss done");
  endtask

  task automatic test_timeout;
    int on_cycles;
    set_tgt(12, 0, 30);
    completeSetting = 1'b1;
    tick(1);
    checks++;
    if (remain_sec !== 17'd0 || armed !== 1'b1) begin
      errors++; $display("FAIL arm_equal_now: armed %b remain %0d expected 1 and 0", armed, remain_sec);
    end
    completeSetting = 1'b0;
    tick(1);
    on_cycles = 0;
    while (alarm_on === 1'b1 && on_cycles < 100) begin
      on_cycles++;
      tick(1);
    end
    checks++;
    if (on_cycles != 30) begin
      errors++; $display("FAIL ring_timeout: ringing cycles got %0d expected 30", on_cycles);
    end
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: armed got %b expected 0", armed);
    end
    $display("test_timeout done");
  endtask

  task automatic test_wrap_and_err;
    set_now(23, 59, 50); set_tgt(0, 0, 20);
    completeSetting = 1'b1;
    tick(1);
    checks++;
    if (remain_sec !== 17'd30 || armed !== 1'b1) begin
      errors++; $display("FAIL wrap_remain: armed %b remain %0d expected 1 and 30", armed, remain_sec);
    end
    completeSetting = 1'b0;
    sharp = 1'b1;
    tick(1);
    checks++;
    if (armed !== 1'b0 || remain_sec !== 17'd0) begin
      errors++; $display("FAIL cancel_nap: armed %b remain %0d expected 0 and 0", armed, remain_sec);
    end
    sharp = 1'b0;
    set_tgt(12, 0, 0);
    min_ten_tgt = 4'd6; min_one_tgt = 4'hA;
    completeSetting = 1'b1;
    tick(1);
    checks++;
    if (set_err !== 1'b1 || armed !== 1'b0) begin
      errors++; $display("FAIL set_err_pulse: set_err %b armed %b expected 1 and 0", set_err, armed);
    end
    tick(1);
    checks++;
    if (set_err !== 1'b0) begin
      errors++; $display("FAIL set_err_clear: got %b expected 0", set_err);
    end
    completeSetting = 1'b0;
    set_tgt(24, 0, 0);
    tick(1);
    completeSetting = 1'b1;
    tick(1);
    checks++;
    if (set_err !== 1'b1 || armed !== 1'b0) begin
      errors++; $display("FAIL hour_24_reject: set_err %b armed %b expected 1 and 0", set_err, armed);
    end
    completeSetting = 1'b0;
    tick(1);
    $display("test_wrap_and_err done");
  endtask

  task automatic test_snooze_and_rst;
    set_now(12, 0, 0); set_tgt(12, 0, 0);
    completeSetting = 1'b1;
    tick(1);
    completeSetting = 1'b0;
    tick(1);
    checks++;
    if (alarm_on !== 1'b1) begin
      errors++; $display("FAIL snooze_pre_ring: alarm_on got %b expected 1", alarm_on);
    end
    set_tgt(12, 5, 0);
    completeSetting = 1'b1; sharp = 1'b1;
    tick(1);
    checks++;
    if ({armed, alarm_on} !== 2'b10 || remain_sec !== 17'd300) begin
      errors++; $display("FAIL snooze: armed/on %b remain %0d expected 10 and 300", {armed, alarm_on}, remain_sec);
    end
    completeSetting = 1'b0; sharp = 1'b0;
    set_now(12, 5, 0);
    tick(1);
    checks++;
    if (alarm_on !== 1'b1) begin
      errors++; $display("FAIL snooze_ring: alarm_on got %b expected 1", alarm_on);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({armed, alarm_on, alarm_blink, set_err} !== 4'b0000 || remain_sec !== 17'd0) begin
      errors++; $display("FAIL rst_mid_ring: flags %b remain %0d expected 0000 and 0",
                         {armed, alarm_on, alarm_blink, set_err}, remain_sec);
    end
    rst = 1'b0;
    tick(1);
    $display("test_snooze_and_rst done");
  endtask

  task automatic test_enable;
    set_now(12, 0, 0); set_tgt(12, 0, 10);
    completeSetting = 1'b1;
    tick(1);
    completeSetting = 1'b0;
    en = 1'b0;
    set_now(12, 0, 5);
    tick(2);
    checks++;
    if (remain_sec !== 17'd10 || armed !== 1'b1) begin
      errors++; $display("FAIL en_freeze: armed %b remain %0d expected 1 and 10", armed, remain_sec);
    end
    sharp = 1'b1;
    tick(1);
    sharp = 1'b0;
    tick(1);
    en = 1'b1;
    tick(1);
    checks++;
    if (armed !== 1'b1 || remain_sec !== 17'd5) begin
      errors++; $display("FAIL en_edge_ignored: armed %b remain %0d expected 1 and 5", armed, remain_sec);
    end
    $display("test_enable done");
  endtask

  initial begin
    test_reset();
    test_arm();
    test_ring_blink();
    test_dismiss();
    test_timeout();
    test_wrap_and_err();
    test_snooze_and_rst();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
